// File: rtl/mem_wb_controller_pkg.sv
// mem_wb_controller_pkg
// Shared pipeline definitions for the MEM->WB boundary:
//   - writeback source select encodings driven on wb_sel
//   - state type of the data-memory access sequencer
package mem_wb_controller_pkg;

    // Writeback mux source select
    localparam logic [1:0] WB_SEL_PC  = 2'b00;  // return address of call
    localparam logic [1:0] WB_SEL_ALU = 2'b01;  // ALU result (ALU ops, jmpl)
    localparam logic [1:0] WB_SEL_MEM = 2'b10;  // data-memory read data

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_controller.sv
// mem_wb_controller
// Sequences the MEM->WB pipeline boundary around a variable-latency data
// memory. Decodes the MEM-stage instruction class, runs the data-memory
// request handshake, stalls IF..MEM while an access is outstanding and
// produces the registered writeback select / enable / destination.
//
// Parameters:
//   TIMEOUT  maximum number of ACCESS cycles before the access is aborted (>=2)
//   CNT_W    width of the access cycle counter
// Ports:
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   MEM_call_instr   call in MEM (writes back PC)
//   MEM_jmpl_instr   jmpl in MEM (writes back ALU result)
//   MEM_load_instr   load in MEM (memory read)
//   MEM_store_instr  store in MEM (memory write, no writeback)
//   MEM_rf_enable    MEM instruction writes the register file
//   MEM_rd           MEM destination register
//   MEM_flush        squash MEM instruction / outstanding access
//   dm_ready         data memory completes the access this cycle
//   dm_req           registered data-memory request
//   dm_rw            1 = write, 0 = read; valid while dm_req
//   mem_stall        combinational freeze of IF..MEM
//   wb_sel           registered writeback source select
//   wb_rf_enable     registered register-file write enable
//   wb_rd            registered destination register
//   timeout_err      one-cycle pulse after an access timed out
module mem_wb_controller
    import mem_wb_controller_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MEM_call_instr,
    input  logic       MEM_jmpl_instr,
    input  logic       MEM_load_instr,
    input  logic       MEM_store_instr,
    input  logic       MEM_rf_enable,
    input  logic [4:0] MEM_rd,
    input  logic       MEM_flush,
    input  logic       dm_ready,
    output logic       dm_req,
    output logic       dm_rw,
    output logic       mem_stall,
    output logic [1:0] wb_sel,
    output logic       wb_rf_enable,
    output logic [4:0] wb_rd,
    output logic       timeout_err
);

    mem_wb_state_t    state_reg;
    logic [CNT_W-1:0] count_reg;

    logic mem_op;
    logic last_cycle;

    // jmpl selects the ALU result exactly like ordinary ALU instructions, so
    // it needs no decode of its own; only call steers wb_sel to the PC.
    logic unused_jmpl;
    assign unused_jmpl = MEM_jmpl_instr;

    // Call has priority over load/store: a call with the load bit set never
    // touches memory.
    assign mem_op     = (MEM_load_instr | MEM_store_instr) & ~MEM_call_instr & ~MEM_flush;
    assign last_cycle = (count_reg == CNT_W'(TIMEOUT - 1));

    // Stall is combinational so the request cycle itself already freezes the
    // front of the pipeline; the final ACCESS cycle (ready, flush or timeout)
    // releases it so MEM can advance at the same edge the FSM returns to IDLE.
    always_comb begin
        mem_stall = 1'b0;
        if (state_reg == IDLE) begin
            mem_stall = mem_op;
        end else begin
            mem_stall = ~dm_ready & ~MEM_flush & ~last_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dm_req       <= 1'b0;
            dm_rw        <= 1'b0;
            wb_sel       <= WB_SEL_ALU;
            wb_rf_enable <= 1'b0;
            wb_rd        <= 5'd0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        state_reg    <= ACCESS;
                        dm_req       <= 1'b1;
                        dm_rw        <= MEM_store_instr & ~MEM_load_instr;
                        count_reg    <= '0;
                        // WB sees a bubble until the access resolves.
                        wb_rf_enable <= 1'b0;
                    end else begin
                        wb_sel       <= MEM_call_instr ? WB_SEL_PC : WB_SEL_ALU;
                        wb_rf_enable <= MEM_rf_enable & ~MEM_flush;
                        wb_rd        <= MEM_rd;
                    end
                end

                ACCESS: begin
                    if (MEM_flush) begin
                        // Abort wins over a simultaneous ready.
                        state_reg    <= IDLE;
                        dm_req       <= 1'b0;
                        wb_rf_enable <= 1'b0;
                    end else if (dm_ready) begin
                        state_reg <= IDLE;
                        dm_req    <= 1'b0;
                        // MEM is frozen during the access, so MEM_rd and
                        // MEM_rf_enable still describe the load here.
                        if (!dm_rw) begin
                            wb_sel       <= WB_SEL_MEM;
                            wb_rf_enable <= MEM_rf_enable;
                            wb_rd        <= MEM_rd;
                        end else begin
                            wb_rf_enable <= 1'b0;
                        end
                    end else if (last_cycle) begin
                        state_reg    <= IDLE;
                        dm_req       <= 1'b0;
                        wb_rf_enable <= 1'b0;
                        timeout_err  <= 1'b1;
                    end else begin
                        count_reg    <= count_reg + CNT_W'(1);
                        wb_rf_enable <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    dm_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_controller.sv
// Directed testbench for mem_wb_controller (TIMEOUT = 15).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later,
// well away from the next rising edge.
module tb_mem_wb_controller;

    logic       clk;
    logic       rst_n;
    logic       MEM_call_instr;
    logic       MEM_jmpl_instr;
    logic       MEM_load_instr;
    logic       MEM_store_instr;
    logic       MEM_rf_enable;
    logic [4:0] MEM_rd;
    logic       MEM_flush;
    logic       dm_ready;
    logic       dm_req;
    logic       dm_rw;
    logic       mem_stall;
    logic [1:0] wb_sel;
    logic       wb_rf_enable;
    logic [4:0] wb_rd;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_controller #(.TIMEOUT(15)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MEM_call_instr  (MEM_call_instr),
        .MEM_jmpl_instr  (MEM_jmpl_instr),
        .MEM_load_instr  (MEM_load_instr),
        .MEM_store_instr (MEM_store_instr),
        .MEM_rf_enable   (MEM_rf_enable),
        .MEM_rd          (MEM_rd),
        .MEM_flush       (MEM_flush),
        .dm_ready        (dm_ready),
        .dm_req          (dm_req),
        .dm_rw           (dm_rw),
        .mem_stall       (mem_stall),
        .wb_sel          (wb_sel),
        .wb_rf_enable    (wb_rf_enable),
        .wb_rd           (wb_rd),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MEM_call_instr  = 1'b0;
        MEM_jmpl_instr  = 1'b0;
        MEM_load_instr  = 1'b0;
        MEM_store_instr = 1'b0;
        MEM_rf_enable   = 1'b0;
        MEM_rd          = 5'd0;
        MEM_flush       = 1'b0;
        dm_ready        = 1'b0;
    endtask

    initial begin
        int stall_cnt;
        int req_cnt;
        int toe_cnt;

        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset values, before any clock edge (asynchronous reset)
        check("rst_dm_req",   32'(dm_req),       32'd0);
        check("rst_dm_rw",    32'(dm_rw),        32'd0);
        check("rst_wb_sel",   32'(wb_sel),       32'd1);
        check("rst_wb_rf_en", 32'(wb_rf_enable), 32'd0);
        check("rst_wb_rd",    32'(wb_rd),        32'd0);
        check("rst_toe",      32'(timeout_err),  32'd0);
        check("rst_stall",    32'(mem_stall),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ALU op, rd 7; dm_ready high in IDLE must be ignored
        MEM_rf_enable = 1'b1;
        MEM_rd        = 5'd7;
        dm_ready      = 1'b1;
        #1;
        check("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("alu_wb_sel",   32'(wb_sel),       32'd1);
        check("alu_wb_rf_en", 32'(wb_rf_enable), 32'd1);
        check("alu_wb_rd",    32'(wb_rd),        32'd7);
        check("alu_stall2",   32'(mem_stall),    32'd0);
        check("idle_ready_no_req", 32'(dm_req),  32'd0);

        // Call + load, rd 15: treated as call, no memory access
        tick();
        MEM_call_instr = 1'b1;
        MEM_load_instr = 1'b1;
        MEM_rf_enable  = 1'b1;
        MEM_rd         = 5'd15;
        #1;
        check("call_stall", 32'(mem_stall), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("call_wb_sel",   32'(wb_sel),       32'd0);
        check("call_wb_rd",    32'(wb_rd),        32'd15);
        check("call_wb_rf_en", 32'(wb_rf_enable), 32'd1);
        check("call_dm_req",   32'(dm_req),       32'd0);

        // Load rd 3 at cycle N; dm_req rises at N+1, ready at N+4.
        // Stall covers N..N+3 (4 cycles), dm_req high N+1..N+4 (4 cycles).
        tick();
        stall_cnt = 0;
        req_cnt   = 0;
        MEM_load_instr = 1'b1;
        MEM_rf_enable  = 1'b1;
        MEM_rd         = 5'd3;
        for (int c = 0; c <= 4; c++) begin
            dm_ready = (c == 4);
            #1;
            if (mem_stall) stall_cnt++;
            if (dm_req) req_cnt++;
            if (c == 2) begin
                check("ld_dm_rw",        32'(dm_rw),        32'd0);
                check("ld_wb_rf_en_mid", 32'(wb_rf_enable), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
        #1;
        check("ld_stall_cycles", 32'(stall_cnt),    32'd4);
        check("ld_req_cycles",   32'(req_cnt),      32'd4);
        check("ld_wb_sel",       32'(wb_sel),       32'd2);
        check("ld_wb_rf_en",     32'(wb_rf_enable), 32'd1);
        check("ld_wb_rd",        32'(wb_rd),        32'd3);
        check("ld_dm_req_done",  32'(dm_req),       32'd0);

        // Store, ready on first ACCESS cycle: stall 1 cycle, no writeback
        tick();
        stall_cnt = 0;
        MEM_store_instr = 1'b1;
        MEM_rd          = 5'd12;
        #1;
        if (mem_stall) stall_cnt++;
        tick();
        dm_ready = 1'b1;
        #1;
        if (mem_stall) stall_cnt++;
        check("st_dm_req", 32'(dm_req), 32'd1);
        check("st_dm_rw",  32'(dm_rw),  32'd1);
        tick();
        clear_inputs();
        // Back-to-back: a timeout load is presented right away
        MEM_load_instr = 1'b1;
        MEM_rf_enable  = 1'b1;
        MEM_rd         = 5'd9;
        #1;
        check("st_stall_cycles", 32'(stall_cnt),    32'd1);
        check("st_wb_rf_en",     32'(wb_rf_enable), 32'd0);
        check("b2b_gap_req",     32'(dm_req),       32'd0);

        // Load with no ready: 15 ACCESS cycles, then timeout pulse
        stall_cnt = 0;
        req_cnt   = 0;
        toe_cnt   = 0;
        for (int c = 0; c <= 15; c++) begin
            #1;
            if (mem_stall) stall_cnt++;
            if (dm_req) req_cnt++;
            if (timeout_err) toe_cnt++;
            if (c == 1) check("b2b_req_rise", 32'(dm_req), 32'd1);
            if (c == 15) check("to_last_stall", 32'(mem_stall), 32'd0);
            @(posedge clk);
            #1;
        end
        clear_inputs();
        #1;
        check("to_stall_cycles", 32'(stall_cnt),    32'd15);
        check("to_req_cycles",   32'(req_cnt),      32'd15);
        check("to_early_toe",    32'(toe_cnt),      32'd0);
        check("to_toe_pulse",    32'(timeout_err),  32'd1);
        check("to_wb_rf_en",     32'(wb_rf_enable), 32'd0);
        check("to_dm_req",       32'(dm_req),       32'd0);
        // Back in IDLE: an ALU op is captured normally
        tick();
        MEM_rf_enable = 1'b1;
        MEM_rd        = 5'd5;
        #1;
        check("to_toe_one_cycle", 32'(timeout_err), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("to_idle_wb_rf_en", 32'(wb_rf_enable), 32'd1);
        check("to_idle_wb_rd",    32'(wb_rd),        32'd5);
        check("to_idle_wb_sel",   32'(wb_sel),       32'd1);

        // Load, flush together with ready on 2nd ACCESS cycle: abort
        tick();
        MEM_load_instr = 1'b1;
        MEM_rf_enable  = 1'b1;
        MEM_rd         = 5'd4;
        tick();
        tick();
        MEM_flush = 1'b1;
        dm_ready  = 1'b1;
        #1;
        check("fl_stall", 32'(mem_stall), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("fl_dm_req",   32'(dm_req),       32'd0);
        check("fl_wb_rf_en", 32'(wb_rf_enable), 32'd0);
        check("fl_wb_sel",   32'(wb_sel),       32'd1);
        check("fl_toe",      32'(timeout_err),  32'd0);

        // Reset in the middle of an access drops dm_req without a clock edge
        tick();
        MEM_load_instr = 1'b1;
        MEM_rf_enable  = 1'b1;
        MEM_rd         = 5'd6;
        tick();
        tick();
        check("rs_dm_req_before", 32'(dm_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_dm_req_async", 32'(dm_req), 32'd0);
        clear_inputs();
        #1;
        check("rs_stall", 32'(mem_stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rs_dm_req_after", 32'(dm_req),       32'd0);
        check("rs_wb_rf_en",     32'(wb_rf_enable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
